// File: rtl/ub_write_packer_if.sv
// Unified-buffer row write bus. The packer drives a request with address and
// row data; the buffer answers with ready. A write happens on en & ready.
interface ub_write_packer_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 8
);
  logic                 ub_wr_en;
  logic                 ub_wr_ready;
  logic [ADDR_W-1:0]    ub_wr_addr;
  logic [8*LANES-1:0]   ub_wr_data;

  // Row producer (the packer).
  modport master (
    output ub_wr_en,
    output ub_wr_addr,
    output ub_wr_data,
    input  ub_wr_ready
  );

  // Row consumer (the unified buffer).
  modport slave (
    input  ub_wr_en,
    input  ub_wr_addr,
    input  ub_wr_data,
    output ub_wr_ready
  );
endinterface

// File: rtl/ub_write_packer.sv
// Packs the serial int8 stream from the quantize stage into LANES-wide rows
// and writes them to the unified buffer at consecutive addresses starting at
// a programmed base. The upstream pipeline cannot stall, so a small FIFO
// absorbs buffer backpressure; a row arriving at a full FIFO is dropped and
// flagged through the sticky overflow bit.
module ub_write_packer #(
  parameter int LANES      = 4,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_count,
  input  logic              valid_in,
  input  logic [7:0]        data_in,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  ub_write_packer_if.master ub
);

  localparam int ROW_W  = 8 * LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Job registers
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] rows_pushed_q;

  // Row assembly: lanes 0..LANES-2 are held here, the last lane comes
  // straight from data_in on the push edge.
  logic [LANE_W-1:0]      lane_q;
  logic [8*(LANES-1)-1:0] partial_q;

  // Row FIFO. Each entry carries its own address so that a dropped row still
  // consumes its slot in the address sequence and later rows stay positional.
  logic [ROW_W-1:0]  data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    fill_q;

  logic              start_ok;
  logic              byte_ok;
  logic              row_push;
  logic              last_row;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              push_drop;
  logic [ROW_W-1:0]  row_word;
  logic [ADDR_W-1:0] row_addr;

  assign start_ok   = (state_q == S_IDLE) && start;
  assign byte_ok    = (state_q == S_PACK) && valid_in;
  assign row_push   = byte_ok && (lane_q == LAST_LANE);
  assign last_row   = (rows_pushed_q + ADDR_W'(1)) == count_q;
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == FIFO_FULL);
  assign pop        = !fifo_empty && ub.ub_wr_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = row_push && (!fifo_full || pop);
  assign push_drop  = row_push && !push_ok;
  assign row_word   = {data_in, partial_q};
  assign row_addr   = base_q + rows_pushed_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (row_count == '0) ? S_DONE : S_PACK;
      end
      S_PACK: begin
        if (row_push && last_row) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty || ((fill_q == (PTR_W + 1)'(1)) && pop)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job parameters, row counter and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q        <= '0;
      count_q       <= '0;
      rows_pushed_q <= '0;
      overflow      <= 1'b0;
    end else if (start_ok) begin
      base_q        <= base_addr;
      count_q       <= row_count;
      rows_pushed_q <= '0;
      overflow      <= 1'b0;
    end else begin
      if (row_push)  rows_pushed_q <= rows_pushed_q + ADDR_W'(1);
      if (push_drop) overflow      <= 1'b1;
    end
  end

  // Lane counter and partial-row assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q    <= '0;
      partial_q <= '0;
    end else if (start_ok) begin
      lane_q <= '0;
    end else if (byte_ok) begin
      if (lane_q == LAST_LANE) begin
        lane_q <= '0;
      end else begin
        lane_q                    <= lane_q + LANE_W'(1);
        partial_q[8*lane_q +: 8]  <= data_in;
      end
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q <= fill_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
    end
  end

  // FIFO storage.
  // NOTE: the storage array has no reset; its contents are never visible
  // while the FIFO is empty, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr_q] <= row_word;
      addr_mem[wr_ptr_q] <= row_addr;
    end
  end

  // Outputs. The head entry is masked while empty so the bus reads zero
  // after reset; it is otherwise held until the handshake.
  assign ub.ub_wr_en   = !fifo_empty;
  assign ub.ub_wr_addr = fifo_empty ? '0 : addr_mem[rd_ptr_q];
  assign ub.ub_wr_data = fifo_empty ? '0 : data_mem[rd_ptr_q];
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_ub_write_packer.sv
// Directed bench for ub_write_packer. Stimulus pushes the expected UB writes
// into a queue; a monitor pops and compares on every write handshake.
module tb_ub_write_packer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [7:0] row_count = '0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = '0;
  logic       busy;
  logic       done;
  logic       overflow;

  ub_write_packer_if #(.LANES(4), .ADDR_W(8)) ub ();

  ub_write_packer #(.LANES(4), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .row_count (row_count),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .ub        (ub)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake seen at the falling edge completes at the
  // next rising edge, since inputs only change just after rising edges.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (done) done_cnt++;
    if (reset_n && ub.ub_wr_en && ub.ub_wr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                 ub.ub_wr_addr, ub.ub_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ub.ub_wr_addr), 64'(e.addr));
        check("wr_data", 64'(ub.ub_wr_data), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_job(input logic [7:0] b, input logic [7:0] r);
    start     = 1'b1;
    base_addr = b;
    row_count = r;
    step();
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(first + i);
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 64'(seen), 64'(1));
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     64'(busy),           64'(0));
    check({tag, "_done"},     64'(done),           64'(0));
    check({tag, "_overflow"}, 64'(overflow),       64'(0));
    check({tag, "_wr_en"},    64'(ub.ub_wr_en),    64'(0));
    check({tag, "_wr_addr"},  64'(ub.ub_wr_addr),  64'(0));
    check({tag, "_wr_data"},  64'(ub.ub_wr_data),  64'(0));
  endtask

  initial begin
    int d0;
    ub.ub_wr_ready = 1'b1;

    // Reset state
    #12;
    check_all_zero("reset");
    step();
    reset_n = 1'b1;
    step();

    // Test 1: two rows, ready always high
    push_exp(8'h10, 32'h04030201);
    push_exp(8'h11, 32'h08070605);
    d0 = done_cnt;
    start_job(8'h10, 8'd2);
    send_bytes(8'h01, 8);
    wait_done("t1_done", 40);
    repeat (3) step();
    check("t1_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

    // Test 2: backpressure holds the request stable
    ub.ub_wr_ready = 1'b0;
    push_exp(8'h10, 32'h04030201);
    push_exp(8'h11, 32'h08070605);
    start_job(8'h10, 8'd2);
    send_bytes(8'h01, 8);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_wr_en_held", 64'(ub.ub_wr_en),   64'(1));
      check("t2_addr_stable", 64'(ub.ub_wr_addr), 64'(8'h10));
      check("t2_data_stable", 64'(ub.ub_wr_data), 64'(32'h04030201));
    end
    step();
    ub.ub_wr_ready = 1'b1;
    wait_done("t2_done", 40);
    check("t2_overflow", 64'(overflow), 64'(0));
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

    // Test 3: FIFO overflow, rows 5 and 6 dropped
    ub.ub_wr_ready = 1'b0;
    push_exp(8'h40, 32'h23222120);
    push_exp(8'h41, 32'h27262524);
    push_exp(8'h42, 32'h2b2a2928);
    push_exp(8'h43, 32'h2f2e2d2c);
    start_job(8'h40, 8'd6);
    send_bytes(8'h20, 24);
    @(negedge clk);
    check("t3_overflow_set", 64'(overflow),    64'(1));
    check("t3_busy_drain",   64'(busy),        64'(1));
    check("t3_wr_en",        64'(ub.ub_wr_en), 64'(1));
    step();
    ub.ub_wr_ready = 1'b1;
    wait_done("t3_done", 40);
    check("t3_overflow_sticky", 64'(overflow), 64'(1));
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

    // Test 4: address wrap; the start also clears overflow
    push_exp(8'hff, 32'ha4a3a2a1);
    push_exp(8'h00, 32'ha8a7a6a5);
    start_job(8'hff, 8'd2);
    check("t4_overflow_cleared", 64'(overflow), 64'(0));
    send_bytes(8'ha1, 8);
    wait_done("t4_done", 40);
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

    // Test 5: bytes in IDLE and start while busy are ignored; zero-row job
    send_bytes(8'h55, 8);
    @(negedge clk);
    check("t5_idle_bytes_wr_en", 64'(ub.ub_wr_en), 64'(0));
    check("t5_idle_bytes_busy",  64'(busy),        64'(0));
    step();
    push_exp(8'h30, 32'hc4c3c2c1);
    start_job(8'h30, 8'd1);
    start     = 1'b1;
    base_addr = 8'h50;
    row_count = 8'd3;
    valid_in  = 1'b1;
    data_in   = 8'hc1;
    step();
    start = 1'b0;
    send_bytes(8'hc2, 3);
    wait_done("t5_done", 40);
    repeat (2) step();
    check("t5_busy_after", 64'(busy), 64'(0));
    check("t5_queue_empty", 64'(exp_q.size()), 64'(0));
    d0 = done_cnt;
    start_job(8'h77, 8'd0);
    @(negedge clk);
    check("t5_zero_done",  64'(done),        64'(1));
    check("t5_zero_wr_en", 64'(ub.ub_wr_en), 64'(0));
    step();
    @(negedge clk);
    check("t5_zero_done_low", 64'(done), 64'(0));
    check("t5_zero_idle",     64'(busy), 64'(0));
    step();
    check("t5_zero_pulses", 64'(done_cnt - d0), 64'(1));

    // Test 6: asynchronous reset mid-row, then a fresh job
    start_job(8'h60, 8'd1);
    send_bytes(8'he1, 2);
    check("t6_busy_before", 64'(busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    step();
    reset_n = 1'b1;
    step();
    push_exp(8'h70, 32'h14131211);
    start_job(8'h70, 8'd1);
    send_bytes(8'h11, 4);
    wait_done("t6_done", 40);
    repeat (2) step();
    check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
